// File: rtl/us_nn2x_pkg.sv
// Shared constants and types for the 2x nearest-neighbour upscaler.
// Defaults target a 128x128 RGB888 downsampled stream.
package us_nn2x_pkg;

    localparam int US_DATA_WIDTH = 24;
    localparam int US_IN_W       = 128;
    localparam int US_IN_H       = 128;
    localparam int US_COL_W      = $clog2(US_IN_W);
    localparam int US_ROW_W      = $clog2(US_IN_H);
    localparam int US_CNT_W      = $clog2(4 * US_IN_W);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } us_state_e;

endpackage

// File: rtl/us_line_ram.sv
// Ping-pong line store: simple dual-port RAM, bank selects the address MSB.
// The read register is resettable; the array itself is never reset.
module us_line_ram
    import us_nn2x_pkg::*;
#(
    parameter int DATA_WIDTH = US_DATA_WIDTH,
    parameter int IN_W       = US_IN_W,
    parameter int ADDR_W     = $clog2(2 * IN_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [2*IN_W];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between reads so the pixel output stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/us_nn2x.sv
// 2x nearest-neighbour upscaler: lines are captured into a ping-pong store and
// each line is replayed twice with every pixel doubled horizontally.
module us_nn2x
    import us_nn2x_pkg::*;
#(
    parameter int DATA_WIDTH = US_DATA_WIDTH,
    parameter int IN_W       = US_IN_W,
    parameter int IN_H       = US_IN_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ds_data_valid_i,
    input  logic [DATA_WIDTH-1:0] ds_data_i,
    output logic                  us_data_valid_o,
    output logic [DATA_WIDTH-1:0] us_data_o,
    output logic                  us_done_o,
    output logic                  us_ovf_o
);

    localparam int COL_W = $clog2(IN_W);
    localparam int ROW_W = $clog2(IN_H);
    localparam int CNT_W = $clog2(4 * IN_W);

    logic [COL_W-1:0] in_col_q,   in_col_d;
    logic [ROW_W-1:0] in_row_q,   in_row_d;
    logic [ROW_W-1:0] out_line_q, out_line_d;
    logic [CNT_W-1:0] out_cnt_q,  out_cnt_d;
    logic             wr_bank_q,  wr_bank_d;
    logic             rd_bank_q,  rd_bank_d;
    logic [1:0]       full_q,     full_d;
    logic             ovf_q,      ovf_d;
    logic             valid_q,    valid_d;
    logic             done_q,     done_d;
    us_state_e        state_q,    state_d;

    logic wr_accept_s;
    logic line_done_s;
    logic emit_s;
    logic cnt_last_s;
    logic next_ready_s;

    assign wr_accept_s = ds_data_valid_i && !full_q[wr_bank_q];
    assign line_done_s = wr_accept_s && (in_col_q == COL_W'(IN_W - 1));
    assign emit_s      = (state_q == ST_EMIT);
    assign cnt_last_s  = (out_cnt_q == CNT_W'(4 * IN_W - 1));
    // The other bank counts as ready even if its line completes in this very cycle.
    assign next_ready_s = full_q[!rd_bank_q] || (line_done_s && (wr_bank_q != rd_bank_q));

    // Next-state logic for the write side, the read FSM and the output flags.
    always_comb begin
        in_col_d   = in_col_q;
        in_row_d   = in_row_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_d     = full_q;
        ovf_d      = ovf_q;
        out_cnt_d  = out_cnt_q;
        out_line_d = out_line_q;
        state_d    = state_q;

        if (wr_accept_s) begin
            if (line_done_s) begin
                in_col_d          = {COL_W{1'b0}};
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                in_row_d          = (in_row_q == ROW_W'(IN_H - 1)) ? {ROW_W{1'b0}}
                                                                   : in_row_q + ROW_W'(1);
            end else begin
                in_col_d = in_col_q + COL_W'(1);
            end
        end else if (ds_data_valid_i) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = ST_EMIT;
                    out_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (cnt_last_s) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    out_line_d        = (out_line_q == ROW_W'(IN_H - 1)) ? {ROW_W{1'b0}}
                                                                         : out_line_q + ROW_W'(1);
                    out_cnt_d         = {CNT_W{1'b0}};
                    state_d           = next_ready_s ? ST_EMIT : ST_IDLE;
                end else begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = emit_s;
        done_d  = emit_s && cnt_last_s && (out_line_q == ROW_W'(IN_H - 1));
    end

    // State registers; valid/done align with the synchronous RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_col_q   <= {COL_W{1'b0}};
            in_row_q   <= {ROW_W{1'b0}};
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            ovf_q      <= 1'b0;
            out_cnt_q  <= {CNT_W{1'b0}};
            out_line_q <= {ROW_W{1'b0}};
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            in_col_q   <= in_col_d;
            in_row_q   <= in_row_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            out_cnt_q  <= out_cnt_d;
            out_line_q <= out_line_d;
            state_q    <= state_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    us_line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_W       (IN_W),
        .ADDR_W     (COL_W + 1)
    ) u_line_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept_s),
        .wr_addr ({wr_bank_q, in_col_q}),
        .wr_data (ds_data_i),
        .rd_en   (emit_s),
        .rd_addr ({rd_bank_q, out_cnt_q[COL_W:1]}),
        .rd_data (us_data_o)
    );

    assign us_data_valid_o = valid_q;
    assign us_done_o       = done_q;
    assign us_ovf_o        = ovf_q;

endmodule

// File: tb/tb_us_nn2x.sv
// Self-checking bench for us_nn2x: a queue-based line model predicts every
// output cycle, plus directed checks of latency, overflow and reset behaviour.
module tb_us_nn2x;

    localparam int DW       = 24;
    localparam int IN_W     = 128;
    localparam int IN_H     = 128;
    localparam int LINE_OUT = 4 * IN_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ds_valid = 1'b0;
    logic [DW-1:0] ds_data = 24'h0;
    logic          us_valid;
    logic [DW-1:0] us_data;
    logic          us_done;
    logic          us_ovf;

    us_nn2x #(.DATA_WIDTH(DW), .IN_W(IN_W), .IN_H(IN_H)) dut (
        .clk             (clk),
        .rst             (rst),
        .ds_data_valid_i (ds_valid),
        .ds_data_i       (ds_data),
        .us_data_valid_o (us_valid),
        .us_data_o       (us_data),
        .us_done_o       (us_done),
        .us_ovf_o        (us_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: completed lines queued as whole lines, replayed as 2x2 blocks.
    logic [DW-1:0] store_q[$];
    logic [DW-1:0] partial_q[$];
    bit            m_emit = 1'b0;
    int            m_pos  = 0;
    int            m_line = 0;
    bit            m_ovf  = 1'b0;
    bit            e_valid = 1'b0;
    bit            e_done  = 1'b0;
    logic [DW-1:0] e_data  = 24'h0;

    task automatic model_step();
        int pre;
        if (rst) begin
            store_q.delete(); partial_q.delete();
            m_emit = 1'b0; m_pos = 0; m_line = 0; m_ovf = 1'b0;
            e_valid = 1'b0; e_done = 1'b0; e_data = 24'h0;
        end else begin
            pre     = store_q.size() / IN_W;
            e_valid = m_emit;
            e_done  = m_emit && (m_pos == LINE_OUT - 1) && (m_line == IN_H - 1);
            if (m_emit) e_data = store_q[(m_pos % (2 * IN_W)) / 2];
            if (ds_valid) begin
                if (pre < 2) begin
                    partial_q.push_back(ds_data);
                    if (partial_q.size() == IN_W) begin
                        foreach (partial_q[i]) store_q.push_back(partial_q[i]);
                        partial_q.delete();
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (m_emit) begin
                if (m_pos == LINE_OUT - 1) begin
                    for (int i = 0; i < IN_W; i++) void'(store_q.pop_front());
                    m_line = (m_line + 1) % IN_H;
                    m_pos  = 0;
                    m_emit = (store_q.size() >= IN_W);
                end else begin
                    m_pos++;
                end
            end else if (pre > 0) begin
                m_emit = 1'b1;
                m_pos  = 0;
            end
        end
    endtask

    bit            chk_en = 1'b0;
    int            cyc = 0;
    int            last_wr_cyc = 0;
    int            first_valid_cyc = 0;
    int            out_idx = 0;
    int            out_total = 0;
    int            done_cnt = 0;
    int            done_at = 0;
    int            run = 0;
    int            max_run = 0;
    logic [DW-1:0] cap [LINE_OUT];

    // Per-cycle monitor: advance the model, then compare one step after the edge.
    always @(posedge clk) begin
        cyc++;
        if (ds_valid) last_wr_cyc = cyc;
        model_step();
        #1;
        if (chk_en) begin
            check_eq("valid", 32'(us_valid), 32'(e_valid));
            check_eq("data",  32'(us_data),  32'(e_data));
            check_eq("done",  32'(us_done),  32'(e_done));
            check_eq("ovf",   32'(us_ovf),   32'(m_ovf));
        end
        if (rst) begin
            out_idx = 0; run = 0;
        end else if (us_valid) begin
            if (out_idx < LINE_OUT) cap[out_idx] = us_data;
            if (out_idx == 0) first_valid_cyc = cyc;
            out_idx++; out_total++; run++;
            if (run > max_run) max_run = run;
            if (us_done) begin done_cnt++; done_at = out_total; end
        end else begin
            run = 0;
        end
    end

    task automatic drive_px(input logic [DW-1:0] d);
        @(negedge clk); ds_valid = 1'b1; ds_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(negedge clk); ds_valid = 1'b0; end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; ds_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        out_total = 0; done_cnt = 0; done_at = 0; max_run = 0;
    endtask

    initial begin
        logic [DW-1:0] p0;
        int k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_valid", 32'(us_valid), 32'd0);
        check_eq("rst_data",  32'(us_data),  32'd0);
        check_eq("rst_done",  32'(us_done),  32'd0);
        check_eq("rst_ovf",   32'(us_ovf),   32'd0);
        chk_en = 1'b1;

        // Line 0: pixels 0..127, one strobe every 4 cycles.
        do_reset();
        for (int c = 0; c < IN_W; c++) begin drive_px(DW'(c)); idle(3); end
        idle(600);
        check_eq("latency", 32'(first_valid_cyc - last_wr_cyc), 32'd2);
        check_eq("run512",  32'(max_run), 32'd512);
        check_eq("col0",    32'(cap[0]),   32'd0);
        check_eq("col1",    32'(cap[1]),   32'd0);
        check_eq("col254",  32'(cap[254]), 32'd127);
        check_eq("col255",  32'(cap[255]), 32'd127);
        check_eq("pass2_0", 32'(cap[256]), 32'd0);
        check_eq("pass2_e", 32'(cap[511]), 32'd127);

        // Full frame at downsampler cadence.
        do_reset();
        for (int r = 0; r < IN_H; r++) begin
            for (int c = 0; c < IN_W; c++) begin drive_px(DW'($urandom())); idle(1); end
            idle(256);
        end
        idle(700);
        check_eq("frame_px",  32'(out_total), 32'd65536);
        check_eq("done_cnt",  32'(done_cnt),  32'd1);
        check_eq("done_last", 32'(done_at),   32'd65536);
        check_eq("frame_ovf", 32'(us_ovf),    32'd0);

        // Back-to-back strobes: third line overflows, flag is sticky.
        do_reset();
        for (int i = 0; i < 3 * IN_W; i++) drive_px(DW'($urandom()));
        idle(1);
        check_eq("ovf_set", 32'(us_ovf), 32'd1);
        idle(1200);
        check_eq("ovf_sticky", 32'(us_ovf), 32'd1);
        check_eq("ovf_lines", 32'(out_total), 32'd1024);
        do_reset();
        check_eq("ovf_clr", 32'(us_ovf), 32'd0);

        // Line completion coinciding with release of the other bank.
        do_reset();
        for (int i = 0; i < 2 * IN_W - 1; i++) drive_px(DW'($urandom()));
        @(negedge clk); ds_valid = 1'b0;
        k = 0;
        while (!(m_emit && m_pos == LINE_OUT - 1) && k < 2000) begin @(negedge clk); k++; end
        check_eq("sync_wait", 32'(k < 2000), 32'd1);
        ds_valid = 1'b1; ds_data = DW'($urandom());
        @(negedge clk); ds_valid = 1'b0;
        idle(1200);
        check_eq("no_gap", 32'(max_run), 32'd1024);

        // Reset mid-line, then recovery with 0xFFFFFF at the last column.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < IN_W; c++) begin drive_px(DW'($urandom())); idle(1); end
            idle(256);
        end
        for (int c = 0; c < 60; c++) begin drive_px(DW'($urandom())); idle(1); end
        do_reset();
        check_eq("mid_valid", 32'(us_valid), 32'd0);
        check_eq("mid_data",  32'(us_data),  32'd0);
        check_eq("mid_done",  32'(us_done),  32'd0);
        idle(20);
        p0 = DW'($urandom());
        for (int c = 0; c < IN_W - 1; c++) begin
            drive_px((c == 0) ? p0 : DW'($urandom())); idle(1);
        end
        idle(5);
        check_eq("no_early", 32'(out_total), 32'd0);
        drive_px(24'hFFFFFF);
        idle(600);
        check_eq("first_px", 32'(cap[0]),   32'(p0));
        check_eq("ff_254",   32'(cap[254]), 32'hFFFFFF);
        check_eq("ff_255",   32'(cap[255]), 32'hFFFFFF);
        check_eq("rec_px",   32'(out_total), 32'd512);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
